// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates stall sources and exceptions into one coherent
// stall-bus/flush pattern per cycle for the 5-stage core.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned STALL_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall_req,
  input  logic               id_loaduse_req,
  input  logic               ex_div_start,
  input  logic               div_ready,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               except_valid,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               div_busy,
  output logic               div_err
);

  localparam int unsigned CNT_W = $clog2(DIV_TIMEOUT + 1);

  localparam logic [STALL_W-1:0] ST_PC  = STALL_W'(6'b000001);
  localparam logic [STALL_W-1:0] ST_IF  = STALL_W'(6'b000011);
  localparam logic [STALL_W-1:0] ST_ID  = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] ST_EX  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] ST_MEM = STALL_W'(6'b011111);

  typedef enum logic [1:0] {IDLE, DIV_WAIT, MEM_WAIT, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mem_block;
  logic             div_timeout;

  assign mem_block   = mem_req & ~mem_ack;
  // The DIV_TIMEOUT-th cycle spent in DIV_WAIT is the forced-release cycle.
  assign div_timeout = (state_q == DIV_WAIT) && (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) && !div_ready;
  assign div_err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    err_d    = err_q;
    stall    = '0;
    flush    = 1'b0;
    new_pc   = '0;
    div_busy = 1'b0;
    if (except_valid) begin
      flush   = 1'b1;
      new_pc  = EXC_VECTOR;
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        FLUSH: begin
          stall   = ST_PC;
          state_d = IDLE;
        end
        MEM_WAIT: begin
          if (mem_ack) state_d = IDLE;
          else         stall   = ST_MEM;
        end
        DIV_WAIT: begin
          // A memory wait only overrides the stall pattern; the divide keeps running.
          if (mem_block)                      stall = ST_MEM;
          else if (!div_ready && !div_timeout) stall = ST_EX;
          if (div_ready) begin
            state_d = IDLE;
          end else if (div_timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            div_busy = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end
        end
        default: begin
          if (mem_block) begin
            stall   = ST_MEM;
            state_d = MEM_WAIT;
          end else if (ex_div_start) begin
            stall   = ST_EX;
            state_d = DIV_WAIT;
          end else if (id_loaduse_req) begin
            stall = ST_ID;
          end else if (if_stall_req) begin
            stall = ST_IF;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, each cycle checked
// against a priority-ordered reference model of the sequencer.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_loaduse_req, ex_div_start, div_ready;
  logic        mem_req, mem_ack, except_valid;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_busy, div_err;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // reference model state
  bit m_div, m_mem, m_flush, m_err;
  int m_cnt;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  pipe_ctrl #(.EXC_VECTOR(VEC), .DIV_TIMEOUT(40), .STALL_W(6)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_loaduse_req(id_loaduse_req),
    .ex_div_start(ex_div_start), .div_ready(div_ready),
    .mem_req(mem_req), .mem_ack(mem_ack), .except_valid(except_valid),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .div_busy(div_busy), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_div = 0; m_mem = 0; m_flush = 0; m_err = 0; m_cnt = 0;
  endtask

  // One clock cycle: drive after negedge, check combinational outputs, advance model.
  task automatic step(input bit ifs, input bit lu, input bit ds, input bit dr,
                      input bit mr, input bit ma, input bit ex);
    logic [5:0]  e_stall;
    logic [31:0] e_pc;
    bit          e_flush, e_busy;
    bit          n_div, n_mem, n_flush, n_err;
    int          n_cnt, t;
    @(negedge clk);
    if_stall_req = ifs; id_loaduse_req = lu; ex_div_start = ds; div_ready = dr;
    mem_req = mr; mem_ack = ma; except_valid = ex;
    #1;
    e_stall = 6'd0; e_pc = 32'd0; e_flush = 0; e_busy = 0;
    n_div = m_div; n_mem = m_mem; n_flush = m_flush; n_err = m_err; n_cnt = m_cnt;
    if (ex) begin
      e_flush = 1; e_pc = VEC;
      n_flush = 1; n_div = 0; n_mem = 0; n_cnt = 0;
    end else if (m_flush) begin
      e_stall = 6'b000001; n_flush = 0;
    end else if (m_mem) begin
      if (ma) n_mem = 0; else e_stall = 6'b011111;
    end else if (m_div) begin
      t = m_cnt + 1;
      if (mr && !ma)          e_stall = 6'b011111;
      else if (!dr && t < 40) e_stall = 6'b001111;
      if (dr)           n_div = 0;
      else if (t == 40) begin n_div = 0; n_err = 1; end
      else              begin e_busy = 1; n_cnt = t; end
    end else if (mr && !ma) begin
      e_stall = 6'b011111; n_mem = 1;
    end else if (ds) begin
      e_stall = 6'b001111; n_div = 1; n_cnt = 0;
    end else if (lu) begin
      e_stall = 6'b000111;
    end else if (ifs) begin
      e_stall = 6'b000011;
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("new_pc", new_pc, e_pc);
    chk("div_busy", 32'(div_busy), 32'(e_busy));
    chk("div_err", 32'(div_err), 32'(m_err));
    m_div = n_div; m_mem = n_mem; m_flush = n_flush; m_err = n_err; m_cnt = n_cnt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset asserted between edges: outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    if_stall_req = 0; id_loaduse_req = 0; ex_div_start = 0; div_ready = 0;
    mem_req = 0; mem_ack = 0; except_valid = 0;
    #2 rst = 1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    chk("rst_div_busy", 32'(div_busy), 32'd0);
    chk("rst_div_err", 32'(div_err), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit mr_hold;
    rst = 1;
    if_stall_req = 0; id_loaduse_req = 0; ex_div_start = 0; div_ready = 0;
    mem_req = 0; mem_ack = 0; except_valid = 0;
    model_clear();
    do_reset();

    idle(10);
    // divide: start at cycle 5, ready at cycle 17
    idle(4); step(0, 0, 1, 0, 0, 0, 0); idle(11); step(0, 0, 0, 1, 0, 0, 0); idle(2);
    // memory wait: req 3..7, ack at 7; then same-cycle req+ack
    idle(2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0); idle(2);
    // divide timeout, sticky error, cleared only by reset
    step(0, 0, 1, 0, 0, 0, 0); idle(45);
    step(0, 0, 1, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0, 0); idle(2);
    do_reset();
    // exception during DIV_WAIT
    step(0, 0, 1, 0, 0, 0, 0); idle(3); step(0, 0, 0, 0, 0, 0, 1); idle(3);
    // exception during MEM_WAIT, and back-to-back exceptions
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1); step(0, 0, 0, 0, 0, 0, 1); idle(3);
    // arbitration between EX, ID and IF
    step(1, 1, 1, 0, 0, 0, 0); step(1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0); idle(1);
    // memory override inside DIV_WAIT
    step(0, 0, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0); step(0, 0, 0, 1, 0, 0, 0); idle(1);
    // reset mid-wait
    step(0, 0, 1, 0, 0, 0, 0); idle(3); do_reset(); idle(2);

    mr_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      bit ma, dr, ds, ex;
      if (!mr_hold) mr_hold = ($urandom_range(0, 9) == 0);
      ma = mr_hold && ($urandom_range(0, 3) == 0);
      dr = ($urandom_range(0, 49) == 0);
      ds = ($urandom_range(0, 7) == 0);
      ex = ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, ds, dr, mr_hold, ma, ex);
      if (ma || ex) mr_hold = 0;
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
